// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ byte producers
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 8,
  parameter int GAP_CYCLES   = 16,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  output logic                      busy,
  output logic                      err
);
  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;
  // A zero-length gap skips the GAP state entirely
  localparam logic [2:0] AFTER_TX  = GAP_CYCLES > 0 ? GAP : IDLE;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  logic [2:0]    state, state_n;
  logic [IW-1:0] ptr, g;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  logic          timeout;

  // Lowest set request at or after p, wrapping; later (smaller) offsets overwrite earlier ones
  function automatic logic [IW-1:0] pick(input logic [N_REQ-1:0] r, input logic [IW-1:0] p);
    int j;
    pick = p;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = (int'(p) + i) % N_REQ;
      if (r[j]) pick = IW'(j);
    end
  endfunction

  assign g       = pick(req, ptr);
  assign timeout = tcnt == TW'(BUSY_TIMEOUT - 1);

  // Next-state selection for the byte sequencer
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = |req ? START : IDLE;
      START:     state_n = WAIT_BUSY;
      WAIT_BUSY: state_n = tx_busy ? WAIT_DONE : (timeout ? AFTER_TX : WAIT_BUSY);
      WAIT_DONE: state_n = tx_busy ? WAIT_DONE : AFTER_TX;
      GAP:       state_n = gcnt == '0 ? IDLE : GAP;
      default:   state_n = IDLE;
    endcase
  end

  // Registered outputs, pointer and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      tcnt     <= '0;
      gcnt     <= '0;
      ack      <= '0;
      grant_id <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      busy     <= state_n != IDLE;
      ack      <= '0;
      tx_start <= 1'b0;
      if (state == IDLE && |req) begin
        ack      <= N_REQ'(1) << g;
        tx_start <= 1'b1;
        grant_id <= g;
        tx_data  <= req_data[int'(g)*DATA_W +: DATA_W];
      end
      if (state == START) begin
        ptr  <= grant_id == IW'(N_REQ - 1) ? '0 : grant_id + 1'b1;
        tcnt <= '0;
      end
      if (state == WAIT_BUSY && !tx_busy) begin
        tcnt <= tcnt + 1'b1;
        if (timeout) err <= 1'b1;
      end
      if (state_n == GAP && state != GAP) gcnt <= GAP_LOAD;
      else if (state == GAP) gcnt <= gcnt - 1'b1;
    end
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares a single UART transmitter between N_REQ byte producers using round-robin arbitration.
- Sequences each byte into the transmitter: one-cycle tx_start, wait for tx_busy to rise then fall, then insert a programmable idle gap.
- Sits between application logic (counters, test-pattern sources) and the UART TX block inside top.
- Its busy output drives the board busy LED.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width per requester.
- GAP_CYCLES, 16, idle clock cycles inserted after each byte completes; 0 means no gap.
- BUSY_TIMEOUT, 15, maximum cycles to wait for tx_busy to rise after tx_start.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request level.
- req_data  in  N_REQ*DATA_W  flattened bytes; requester i uses bits [i*DATA_W +: DATA_W].
- ack  out  N_REQ  one-cycle pulse: requester's byte captured.
- grant_id  out  clog2(N_REQ)  index of the last granted requester.
- tx_data  out  DATA_W  byte presented to the UART TX.
- tx_start  out  1  one-cycle start strobe to the UART TX.
- tx_busy  in  1  UART TX busy flag.
- busy  out  1  high whenever state is not IDLE.
- err  out  1  sticky flag: tx_busy never rose within BUSY_TIMEOUT; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. ack=0, grant_id=0, tx_data=0, tx_start=0, busy=0, err=0. Round-robin pointer ptr=0, gap/timeout counters=0.
  - Applies immediately mid-transfer; tx_start never glitches high during or on exit from reset.
- All outputs are registered.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - If req!=0, select the first set bit searching ptr, ptr+1, ..., wrapping modulo N_REQ.
  - On that edge, register tx_data=req_data[g], grant_id=g, ack[g]=1, tx_start=1, and go to START.
  - Latency: req sampled at edge k gives ack and tx_start high during cycle k+1.
- START (one cycle): ack and tx_start clear; ptr=(g+1) mod N_REQ; timeout counter=0; go to WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy=1: go to WAIT_DONE.
  - Otherwise increment the timeout counter. On reaching BUSY_TIMEOUT, set err=1 and go to GAP; the byte is abandoned and no retry is made.
- WAIT_DONE: remain while tx_busy=1; on tx_busy=0, load the gap counter and go to GAP. No timeout in this state.
- GAP: count GAP_CYCLES cycles, then go to IDLE. If GAP_CYCLES=0, GAP lasts 0 cycles and the FSM goes directly to IDLE.
- Handshake rules:
  - A requester holds req and req_data stable until it sees its ack.
  - req still high on the first IDLE cycle after ack counts as a new request.
  - req dropped before ack means no grant and no ack.
  - Only one ack bit is ever high at a time, for exactly one cycle.
- Fairness: any continuously asserting requester is granted within N_REQ grants. Changes to req outside IDLE are ignored.
- Simultaneous requests: the lowest index at or after ptr wins. After reset, requester 0 has highest priority.
- Pointer wrap: a grant to N_REQ-1 sets ptr=0.
- busy = (state != IDLE), registered.
- tx_busy already high in IDLE is ignored; arbitration is unaffected.

Test Plan:
- Reset, then req=4'b0001 with req_data[7:0]=8'h9A; model tx_busy high 3 cycles after start for 20 cycles → ack=4'b0001 and tx_start for one cycle, tx_data=8'h9A, grant_id=0, busy high until 16 cycles after tx_busy falls.
- req=4'b1111 held, each requester re-asserting after its ack → grant order 0,1,2,3,0; every ack a single-cycle pulse; at most one ack bit set at a time.
- After a grant to requester 3, assert req=4'b1001 → requester 0 granted next (pointer wrap), then requester 3.
- tx_busy tied low after a grant → err=1 at BUSY_TIMEOUT (15) cycles after START; FSM passes through GAP to IDLE; next request is still served; err stays 1.
- Drop rst_n while in WAIT_DONE → all outputs 0 immediately; after release, req=4'b0100 gives grant_id=2 on the first IDLE grant.
- GAP_CYCLES=0 build, two back-to-back requests → second tx_start occurs 2 cycles after tx_busy falls (one cycle in IDLE, then the registered strobe).
